derr_mb_sequencer: RTL

- Per-macroblock controller for the error-diffusion path of the encoder.
- Walks the frame in raster order and fetches the top diffusion errors for column x from the top-derr RAM. Presents top and left errors to the quantiser datapath, waits for its 48-bit derr result, then fires the diffusion-error store stage with that result.
- Owns the row/column counters, the left-error carry register, the first-row/first-column zeroing and the RAM read port.

---
 rtl/derr_mb_sequencer_pkg.sv | 40 ++++
 rtl/derr_mb_sequencer_if.sv | 43 ++++
 rtl/derr_mb_pos_cnt.sv | 43 ++++
 rtl/derr_mb_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/derr_mb_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// derr_mb_sequencer_pkg : shared lane constants, word types and FSM encoding
// Rev 1.0
// ============================================================================
package derr_mb_sequencer_pkg;

  localparam int DERR_LANE_W = 8;
  localparam int TOP_LANES   = 4;
  localparam int LEFT_LANES  = 4;
  localparam int DERR_LANES  = 6;
  localparam int WORD_W      = DERR_LANE_W * TOP_LANES;
  localparam int DERR_W      = DERR_LANE_W * DERR_LANES;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] S_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] S_WAIT_MB   = 3'd1;
  localparam logic [STATE_W-1:0] S_FETCH     = 3'd2;
  localparam logic [STATE_W-1:0] S_RD_WAIT   = 3'd3;
  localparam logic [STATE_W-1:0] S_ISSUE     = 3'd4;
  localparam logic [STATE_W-1:0] S_WAIT_DONE = 3'd5;
  localparam logic [STATE_W-1:0] S_STORE     = 3'd6;
  localparam logic [STATE_W-1:0] S_NEXT      = 3'd7;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = S_IDLE,
    WAIT_MB   = S_WAIT_MB,
    FETCH     = S_FETCH,
    RD_WAIT   = S_RD_WAIT,
    ISSUE     = S_ISSUE,
    WAIT_DONE = S_WAIT_DONE,
    STORE     = S_STORE,
    NEXT      = S_NEXT
  } state_t;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [DERR_W-1:0] derr_t;

endpackage
`default_nettype wire

// File: rtl/derr_mb_sequencer_if.sv
`default_nettype none
// ============================================================================
// derr_mb_sequencer_if : frame control, top-derr RAM port, datapath and store
// Rev 1.0
// ============================================================================
interface derr_mb_sequencer_if import derr_mb_sequencer_pkg::*; #(
  parameter int XW = 10
) ();

  logic          frame_start;
  logic [XW-1:0] mb_w;
  logic [XW-1:0] mb_h;
  logic          mb_req;
  logic          mb_ack;
  logic          busy;
  logic          frame_done;
  logic          top_rd_en;
  logic [XW-1:0] top_rd_addr;
  word_t         top_rd_data;
  logic          derr_in_valid;
  word_t         top_in;
  word_t         left_in;
  logic          derr_done;
  derr_t         derr_out;
  logic          st_start;
  logic [XW-1:0] st_x;
  derr_t         st_derr;
  word_t         left_derr;

  modport master (
    input  frame_start, mb_w, mb_h, mb_req, top_rd_data, derr_done, derr_out, left_derr,
    output mb_ack, busy, frame_done, top_rd_en, top_rd_addr, derr_in_valid,
           top_in, left_in, st_start, st_x, st_derr
  );

  modport slave (
    output frame_start, mb_w, mb_h, mb_req, top_rd_data, derr_done, derr_out, left_derr,
    input  mb_ack, busy, frame_done, top_rd_en, top_rd_addr, derr_in_valid,
           top_in, left_in, st_start, st_x, st_derr
  );

endinterface
`default_nettype wire

// File: rtl/derr_mb_pos_cnt.sv
`default_nettype none
// ============================================================================
// derr_mb_pos_cnt : raster x/y macroblock position with row wrap and end flags
// Rev 1.0
// ============================================================================
module derr_mb_pos_cnt #(
  parameter int XW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  input  logic [XW-1:0] mb_w,
  input  logic [XW-1:0] mb_h,
  output logic [XW-1:0] x,
  output logic [XW-1:0] y,
  output logic          last_col,
  output logic          last_mb
);

  // Flags are only meaningful for non-zero sizes; zero-size frames never advance.
  assign last_col = (x == mb_w - XW'(1));
  assign last_mb  = last_col && (y == mb_h - XW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_col) begin
        x <= '0;
        y <= last_mb ? '0 : y + XW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/derr_mb_sequencer.sv
`default_nettype none
// ============================================================================
// derr_mb_sequencer : per-macroblock error-diffusion controller (raster walk)
// Rev 1.0
// ============================================================================
module derr_mb_sequencer import derr_mb_sequencer_pkg::*; #(
  parameter int XW     = 10,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  derr_mb_sequencer_if.master bus
);

  localparam int RDC_W = 2;

  state_t          state;
  logic [XW-1:0]   mb_w_q;
  logic [XW-1:0]   mb_h_q;
  word_t           left_reg;
  word_t           top_reg;
  logic [RDC_W-1:0] rd_cnt;

  logic            mb_ack_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            top_rd_en_q;
  logic [XW-1:0]   top_rd_addr_q;
  logic            derr_in_valid_q;
  word_t           top_in_q;
  word_t           left_in_q;
  logic            st_start_q;
  logic [XW-1:0]   st_x_q;
  derr_t           st_derr_q;

  logic [XW-1:0]   x;
  logic [XW-1:0]   y;
  logic            last_col;
  logic            last_mb;
  logic            pos_clear;
  logic            pos_advance;

  // A frame_start in NEXT restarts the walk, so it must win over the advance.
  assign pos_clear   = bus.frame_start;
  assign pos_advance = (state == NEXT) && !bus.frame_start;

  derr_mb_pos_cnt #(.XW(XW)) u_pos (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pos_clear),
    .advance  (pos_advance),
    .mb_w     (mb_w_q),
    .mb_h     (mb_h_q),
    .x        (x),
    .y        (y),
    .last_col (last_col),
    .last_mb  (last_mb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mb_w_q          <= '0;
      mb_h_q          <= '0;
      left_reg        <= '0;
      top_reg         <= '0;
      rd_cnt          <= '0;
      mb_ack_q        <= 1'b0;
      busy_q          <= 1'b0;
      frame_done_q    <= 1'b0;
      top_rd_en_q     <= 1'b0;
      top_rd_addr_q   <= '0;
      derr_in_valid_q <= 1'b0;
      top_in_q        <= '0;
      left_in_q       <= '0;
      st_start_q      <= 1'b0;
      st_x_q          <= '0;
      st_derr_q       <= '0;
    end else begin
      mb_ack_q        <= 1'b0;
      frame_done_q    <= 1'b0;
      top_rd_en_q     <= 1'b0;
      derr_in_valid_q <= 1'b0;
      st_start_q      <= 1'b0;

      if (bus.frame_start) begin
        // Also the abort path: any in-flight read or datapath result is dropped.
        mb_w_q   <= bus.mb_w;
        mb_h_q   <= bus.mb_h;
        left_reg <= '0;
        if (bus.mb_w == '0 || bus.mb_h == '0) begin
          frame_done_q <= 1'b1;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end else begin
          busy_q <= 1'b1;
          state  <= WAIT_MB;
        end
      end else begin
        case (state)
          IDLE: begin
            busy_q <= 1'b0;
          end
          WAIT_MB: begin
            if (bus.mb_req) begin
              mb_ack_q <= 1'b1;
              if (y == '0) begin
                top_reg <= '0;
                state   <= ISSUE;
              end else begin
                // Read strobe is visible during FETCH so data lands RD_LAT later.
                top_rd_en_q   <= 1'b1;
                top_rd_addr_q <= x;
                state         <= FETCH;
              end
            end
          end
          FETCH: begin
            rd_cnt <= RDC_W'(1);
            state  <= RD_WAIT;
          end
          RD_WAIT: begin
            if (rd_cnt == RDC_W'(RD_LAT)) begin
              top_reg <= bus.top_rd_data;
              state   <= ISSUE;
            end else begin
              rd_cnt <= rd_cnt + RDC_W'(1);
            end
          end
          ISSUE: begin
            derr_in_valid_q <= 1'b1;
            top_in_q        <= top_reg;
            left_in_q       <= left_reg;
            state           <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (bus.derr_done) begin
              st_derr_q  <= bus.derr_out;
              st_start_q <= 1'b1;
              st_x_q     <= x;
              state      <= STORE;
            end
          end
          STORE: begin
            state <= NEXT;
          end
          NEXT: begin
            if (last_col) begin
              left_reg <= '0;
              if (last_mb) begin
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state        <= IDLE;
              end else begin
                state <= WAIT_MB;
              end
            end else begin
              left_reg <= bus.left_derr;
              state    <= WAIT_MB;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.mb_ack        = mb_ack_q;
  assign bus.busy          = busy_q;
  assign bus.frame_done    = frame_done_q;
  assign bus.top_rd_en     = top_rd_en_q;
  assign bus.top_rd_addr   = top_rd_addr_q;
  assign bus.derr_in_valid = derr_in_valid_q;
  assign bus.top_in        = top_in_q;
  assign bus.left_in       = left_in_q;
  assign bus.st_start      = st_start_q;
  assign bus.st_x          = st_x_q;
  assign bus.st_derr       = st_derr_q;

endmodule
`default_nettype wire
